axi_wr_arb_2m1s: RTL and testbench

- Write-path arbiter that shares one AXI slave write port (e.g. the MRAM slave controller) between two AXI masters (MCU and DMA).
- Round-robin grant on AW, with the W channel locked to the granted master until WLAST.
- B responses are routed back through an in-order master-index FIFO.
- Sits in the NoC slave-side path in front of the MRAM controller; the read path is handled elsewhere.

---
 rtl/axi_wr_arb_2m1s.sv | 179 +++++++++++++++++
 tb/tb_axi_wr_arb_2m1s.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arb_2m1s.sv
// Two-master to one-slave AXI write arbiter: round-robin AW grant, W locked
// to the granted master until wlast, B routed back through an in-order FIFO.
// Ports: clk, rst_n (async low); m0_*/m1_* master AW/W/B channels;
// s_* slave AW/W/B channels; err_b_unexpected (sticky, B with no entry).
module axi_wr_arb_2m1s #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int OUTSTANDING    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ID_WIDTH-1:0]   m0_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] m0_awaddr,
    input  logic [7:0]                m0_awlen,
    input  logic                      m0_awvalid,
    output logic                      m0_awready,
    input  logic [AXI_DATA_WIDTH-1:0] m0_wdata,
    input  logic                      m0_wlast,
    input  logic                      m0_wvalid,
    output logic                      m0_wready,
    output logic [AXI_ID_WIDTH-1:0]   m0_bid,
    output logic [1:0]                m0_bresp,
    output logic                      m0_bvalid,
    input  logic                      m0_bready,
    input  logic [AXI_ID_WIDTH-1:0]   m1_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] m1_awaddr,
    input  logic [7:0]                m1_awlen,
    input  logic                      m1_awvalid,
    output logic                      m1_awready,
    input  logic [AXI_DATA_WIDTH-1:0] m1_wdata,
    input  logic                      m1_wlast,
    input  logic                      m1_wvalid,
    output logic                      m1_wready,
    output logic [AXI_ID_WIDTH-1:0]   m1_bid,
    output logic [1:0]                m1_bresp,
    output logic                      m1_bvalid,
    input  logic                      m1_bready,
    output logic [AXI_ID_WIDTH-1:0]   s_awid,
    output logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    output logic [7:0]                s_awlen,
    output logic                      s_awvalid,
    input  logic                      s_awready,
    output logic [AXI_DATA_WIDTH-1:0] s_wdata,
    output logic                      s_wlast,
    output logic                      s_wvalid,
    input  logic                      s_wready,
    input  logic [AXI_ID_WIDTH-1:0]   s_bid,
    input  logic [1:0]                s_bresp,
    input  logic                      s_bvalid,
    output logic                      s_bready,
    output logic                      err_b_unexpected
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PW:0] DEPTH = (PW+1)'(OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   gnt, gnt_nxt;
    logic   prio, prio_nxt;

    logic [OUTSTANDING-1:0] route_q;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            cnt;
    logic                   err_q;

    logic empty, full, push, pop;
    logic head, head_bready;

    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH);

    // Payload muxes follow the registered grant; only valid/ready are gated.
    assign s_awid   = gnt ? m1_awid   : m0_awid;
    assign s_awaddr = gnt ? m1_awaddr : m0_awaddr;
    assign s_awlen  = gnt ? m1_awlen  : m0_awlen;
    assign s_wdata  = gnt ? m1_wdata  : m0_wdata;
    assign s_wlast  = gnt ? m1_wlast  : m0_wlast;

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        prio_nxt   = prio;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        unique case (state)
            IDLE: begin
                if ((m0_awvalid || m1_awvalid) && !full) begin
                    state_nxt = AW;
                    // Tie goes to the pointer; a lone requester always wins.
                    if (m0_awvalid && m1_awvalid)
                        gnt_nxt = prio;
                    else
                        gnt_nxt = m1_awvalid;
                end
            end
            AW: begin
                s_awvalid  = gnt ? m1_awvalid : m0_awvalid;
                m0_awready = !gnt && s_awready;
                m1_awready = gnt && s_awready;
                if (s_awvalid && s_awready)
                    state_nxt = W;
            end
            W: begin
                s_wvalid  = gnt ? m1_wvalid : m0_wvalid;
                m0_wready = !gnt && s_wready;
                m1_wready = gnt && s_wready;
                if (s_wvalid && s_wready && s_wlast) begin
                    state_nxt = IDLE;
                    prio_nxt  = !gnt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign push = (state == AW) && s_awvalid && s_awready;

    // B path: the FIFO head names the master owed the oldest response.
    assign head        = route_q[rd_ptr];
    assign head_bready = head ? m1_bready : m0_bready;
    assign s_bready    = !empty && head_bready;
    assign pop         = s_bvalid && s_bready;

    assign m0_bvalid = s_bvalid && !empty && !head;
    assign m1_bvalid = s_bvalid && !empty && head;
    assign m0_bid    = s_bid;
    assign m1_bid    = s_bid;
    assign m0_bresp  = s_bresp;
    assign m1_bresp  = s_bresp;

    assign err_b_unexpected = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            prio  <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            prio  <= prio_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                route_q[wr_ptr] <= gnt;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
            if (s_bvalid && empty)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_wr_arb_2m1s.sv
// Directed self-checking bench for axi_wr_arb_2m1s.
// Drives both masters and a scripted slave; checks grant, W lock, B route.
module tb_axi_wr_arb_2m1s;

    localparam int IW = 4;
    localparam int AWD = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0]  m0_awid, m1_awid, m0_bid, m1_bid;
    logic [AWD-1:0] m0_awaddr, m1_awaddr;
    logic [7:0]     m0_awlen, m1_awlen;
    logic           m0_awvalid, m1_awvalid, m0_awready, m1_awready;
    logic [DW-1:0]  m0_wdata, m1_wdata;
    logic           m0_wlast, m1_wlast, m0_wvalid, m1_wvalid;
    logic           m0_wready, m1_wready;
    logic [1:0]     m0_bresp, m1_bresp;
    logic           m0_bvalid, m1_bvalid, m0_bready, m1_bready;
    logic [IW-1:0]  s_awid, s_bid;
    logic [AWD-1:0] s_awaddr;
    logic [7:0]     s_awlen;
    logic           s_awvalid, s_awready;
    logic [DW-1:0]  s_wdata;
    logic           s_wlast, s_wvalid, s_wready;
    logic [1:0]     s_bresp;
    logic           s_bvalid, s_bready, err_b_unexpected;

    axi_wr_arb_2m1s #(
        .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AWD),
        .AXI_DATA_WIDTH(DW), .OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wlast(m0_wlast),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bid(m0_bid), .m0_bresp(m0_bresp),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wlast(m1_wlast),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bid(m1_bid), .m1_bresp(m1_bresp),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .err_b_unexpected(err_b_unexpected)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int aw_cnt = 0;
    int w_cnt = 0;

    // Inputs settle by +4 after posedge, so negedge sees the edge values.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_awvalid && s_awready) aw_cnt++;
            if (s_wvalid && s_wready) w_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic awrdy(input int m);
        return (m == 1) ? m1_awready : m0_awready;
    endfunction

    function automatic logic wrdy(input int m);
        return (m == 1) ? m1_wready : m0_wready;
    endfunction

    task automatic set_aw(input int m, input logic v, input logic [31:0] a,
                          input logic [7:0] len, input logic [3:0] id);
        if (m == 1) begin
            m1_awvalid = v; m1_awaddr = a; m1_awlen = len; m1_awid = id;
        end else begin
            m0_awvalid = v; m0_awaddr = a; m0_awlen = len; m0_awid = id;
        end
    endtask

    task automatic set_w(input int m, input logic v, input logic [63:0] d,
                         input logic l);
        if (m == 1) begin
            m1_wvalid = v; m1_wdata = d; m1_wlast = l;
        end else begin
            m0_wvalid = v; m0_wdata = d; m0_wlast = l;
        end
    endtask

    task automatic do_write(input int m, input logic [31:0] a,
                            input logic [7:0] len, input logic [3:0] id,
                            input logic [63:0] base);
        int t;
        set_aw(m, 1'b1, a, len, id);
        #1;
        t = 0;
        while (!awrdy(m) && t < 30) begin
            cyc();
            t++;
        end
        if (t >= 30) check("aw_timeout", 0, 1);
        check("s_awaddr", s_awaddr, 64'(a));
        check("s_awid", s_awid, 64'(id));
        cyc();
        set_aw(m, 1'b0, a, len, id);
        for (int b = 0; b <= int'(len); b++) begin
            set_w(m, 1'b1, base + 64'(b), b == int'(len));
            #1;
            t = 0;
            while (!wrdy(m) && t < 30) begin
                cyc();
                t++;
            end
            if (t >= 30) check("w_timeout", 0, 1);
            check("s_wdata", s_wdata, base + 64'(b));
            check("w_lock", wrdy(1 - m), 0);
            cyc();
        end
        set_w(m, 1'b0, '0, 1'b0);
    endtask

    task automatic b_one(input int m, input logic [3:0] id,
                         input logic [1:0] resp);
        s_bvalid = 1'b1; s_bid = id; s_bresp = resp;
        #1;
        check("bvalid_tgt", (m == 1) ? m1_bvalid : m0_bvalid, 1);
        check("bvalid_oth", (m == 1) ? m0_bvalid : m1_bvalid, 0);
        check("bid", (m == 1) ? m1_bid : m0_bid, 64'(id));
        check("bresp", (m == 1) ? m1_bresp : m0_bresp, 64'(resp));
        cyc();
        s_bvalid = 1'b0;
    endtask

    initial begin
        set_aw(0, 1'b0, '0, '0, '0);
        set_aw(1, 1'b0, '0, '0, '0);
        set_w(0, 1'b0, '0, 1'b0);
        set_w(1, 1'b0, '0, 1'b0);
        m0_bready = 1'b1; m1_bready = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1;
        s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;

        repeat (2) cyc();
        m0_awvalid = 1'b1;
        #1;
        check("rst_s_awvalid", s_awvalid, 0);
        check("rst_m0_awready", m0_awready, 0);
        check("rst_m0_wready", m0_wready, 0);
        check("rst_s_wvalid", s_wvalid, 0);
        check("rst_s_bready", s_bready, 0);
        check("rst_err", err_b_unexpected, 0);
        m0_awvalid = 1'b0;
        cyc();
        rst_n = 1'b1;

        // Contention straight after reset: m0 first, then alternation.
        cyc();
        set_aw(0, 1'b1, 32'h200, 8'd1, 4'd1);
        set_aw(1, 1'b1, 32'h300, 8'd1, 4'd2);
        set_w(1, 1'b1, 64'hB0, 1'b0);
        #1;
        check("bubble_m0", m0_awready, 0);
        check("bubble_m1", m1_awready, 0);
        check("early_w_m1", m1_wready, 0);
        cyc();
        #1;
        check("tie1_m0", m0_awready, 1);
        check("tie1_m1", m1_awready, 0);
        do_write(0, 32'h200, 8'd1, 4'd1, 64'hC0);
        set_aw(0, 1'b1, 32'h210, 8'd0, 4'd3);
        cyc();
        #1;
        check("tie2_m1", m1_awready, 1);
        check("tie2_m0", m0_awready, 0);
        do_write(1, 32'h300, 8'd1, 4'd2, 64'hB0);
        set_aw(1, 1'b1, 32'h310, 8'd0, 4'd4);
        cyc();
        #1;
        check("tie3_m0", m0_awready, 1);
        check("tie3_m1", m1_awready, 0);
        do_write(0, 32'h210, 8'd0, 4'd3, 64'hD0);
        do_write(1, 32'h310, 8'd0, 4'd4, 64'hE0);
        check("cont_aw_cnt", aw_cnt, 4);
        check("cont_w_cnt", w_cnt, 6);

        // B routing in AW order m0,m1,m0,m1 with an m1 bready stall.
        b_one(0, 4'd1, 2'b00);
        m1_bready = 1'b0;
        s_bvalid = 1'b1; s_bid = 4'd2;
        #1;
        check("stall_s_bready", s_bready, 0);
        check("stall_m1_bvalid", m1_bvalid, 1);
        check("stall_m0_bvalid", m0_bvalid, 0);
        cyc();
        m1_bready = 1'b1;
        b_one(1, 4'd2, 2'b10);
        b_one(0, 4'd3, 2'b01);
        b_one(1, 4'd4, 2'b11);
        #1;
        check("drain_empty", s_bready, 0);

        // Single 4-beat write from m0.
        cyc();
        do_write(0, 32'h100, 8'd3, 4'd5, 64'hA0);
        check("single_aw_cnt", aw_cnt, 5);
        check("single_w_cnt", w_cnt, 10);
        b_one(0, 4'd5, 2'b00);
        #1;
        check("single_empty", s_bready, 0);

        // Outstanding limit: four accepted, fifth waits for a B.
        cyc();
        for (int i = 0; i < 4; i++)
            do_write(0, 32'h400 + 32'(i * 8), 8'd0, 4'(i), 64'h10 + 64'(i));
        set_aw(0, 1'b1, 32'h500, 8'd0, 4'd9);
        repeat (3) cyc();
        #1;
        check("full_awready", m0_awready, 0);
        check("full_s_awvalid", s_awvalid, 0);
        check("full_aw_cnt", aw_cnt, 9);
        b_one(0, 4'd0, 2'b00);
        do_write(0, 32'h500, 8'd0, 4'd9, 64'h20);
        check("fifth_aw_cnt", aw_cnt, 10);
        b_one(0, 4'd1, 2'b00);
        b_one(0, 4'd2, 2'b00);
        b_one(0, 4'd3, 2'b00);
        b_one(0, 4'd9, 2'b00);
        #1;
        check("out_empty", s_bready, 0);

        // Unexpected B with nothing outstanding.
        cyc();
        s_bvalid = 1'b1; s_bid = 4'd7;
        #1;
        check("unexp_s_bready", s_bready, 0);
        check("unexp_m0_bvalid", m0_bvalid, 0);
        check("unexp_m1_bvalid", m1_bvalid, 0);
        check("unexp_err_pre", err_b_unexpected, 0);
        cyc();
        #1;
        check("unexp_err_set", err_b_unexpected, 1);
        s_bvalid = 1'b0;
        cyc();
        #1;
        check("unexp_err_sticky", err_b_unexpected, 1);

        // Reset in the middle of a W burst.
        cyc();
        begin
            int t;
            set_aw(0, 1'b1, 32'h700, 8'd3, 4'd6);
            #1;
            t = 0;
            while (!m0_awready && t < 30) begin
                cyc();
                t++;
            end
            if (t >= 30) check("rst_aw_timeout", 0, 1);
        end
        cyc();
        set_aw(0, 1'b0, '0, '0, '0);
        set_w(0, 1'b1, 64'h70, 1'b0);
        #1;
        check("mid_m0_wready", m0_wready, 1);
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_s_wvalid", s_wvalid, 0);
        check("mid_rst_m0_wready", m0_wready, 0);
        check("mid_rst_s_awvalid", s_awvalid, 0);
        check("mid_rst_s_bready", s_bready, 0);
        check("mid_rst_err", err_b_unexpected, 0);
        set_w(0, 1'b0, '0, 1'b0);
        cyc();
        rst_n = 1'b1;
        do_write(1, 32'h600, 8'd0, 4'd7, 64'hF0);
        b_one(1, 4'd7, 2'b00);
        #1;
        check("post_rst_empty", s_bready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
